mem_test_seq: RTL and testbench
===============================

# mem_test_seq

Parametrised memory test sequencer that drives a single-port synchronous RAM through a full write pass and a verifying read pass over every address. It generates the data pattern, checks read-back data, counts mismatches and latches the first failing address. It advances either one step per `next` press (board push-button) or every cycle in free-run mode. It sits between board controls and a memory instance, and serves as the bring-up and regression harness for every RAM in the design.

## Interface
- `DATA_WIDTH`, 16: memory word width; minimum 2.
- `ADDR_WIDTH`, 10: address width; depth = 2^ADDR_WIDTH.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `next`  in  1  step request; level input, rising edge detected internally.
- `run`  in  1  free-run: step enable every cycle while high.
- `mode`  in  2  pattern select, sampled when leaving IDLE.
- `data_in`  in  DATA_WIDTH  RAM read data (valid one cycle after address sampled).
- `wr_en`  out  1  RAM write enable.
- `addr`  out  ADDR_WIDTH  RAM address.
- `data_out`  out  DATA_WIDTH  RAM write data.
- `busy`  out  1  high in WRITE, READ, CHECK.
- `done`  out  1  high in DONE.
- `error`  out  1  sticky; set on first mismatch of a run.
- `err_addr`  out  ADDR_WIDTH  address of the first mismatch.
- `err_count`  out  16  mismatch count, saturating at 16'hFFFF.

## Operation
- Step enable `en`: registered `next & ~next_prev`, so it is one cycle wide and comes one cycle after `next` rises. `en` is also forced high every cycle while `run`=1.
- Holding `next` high gives exactly one step.
- `next_prev` clears on reset. If `next` is high at reset release, it does not count as a new edge.
- Pattern P(a) for address a, with a zero-extended or truncated to DATA_WIDTH:
  - mode 0: a.
  - mode 1: alternating 1010… if a[0]=0, else 0101… (16 bits: AAAA / 5555).
  - mode 2: ~a.
  - mode 3: all ones.
- States:
  - IDLE: outputs idle. On `en`: latch `mode`, clear `error`/`err_count`/`err_addr`, set the address counter to 0, go to WRITE.
  - WRITE: `wr_en`=1, `addr`=counter, `data_out`=P(counter). On `en`: if the counter is at its maximum, reset it to 0 and go to READ; otherwise increment it.
  - READ: `wr_en`=0, `addr`=counter, `data_out`=0. On `en`: go to CHECK.
  - CHECK: `addr` held. Exactly one cycle and unconditional (no `en` needed). At the end of the cycle, compare `data_in` with P(counter).
    - On mismatch: increment `err_count` (saturating). If `error` is 0, latch `err_addr`=counter and set `error`.
    - Then, if the counter is at its maximum, go to DONE; otherwise increment it and go to READ.
  - DONE: outputs idle, `done`=1, results held. On `en`: go to IDLE; results are kept until the next start.
- Idle outputs: `wr_en`=0, `addr`=0, `data_out`=0.
- The address counter is ADDR_WIDTH wide. The terminal test is on all ones; there is no wrap-around inside a pass.
- `mode` changes during a run are ignored.
- `run` and `next` together behave the same as `run` alone.

## Timing
- Reset (`reset`=0 at a clock edge) forces the following values on the next cycle, regardless of state, including mid-pass:
  - state IDLE.
  - `wr_en`=0, `addr`=0, `data_out`=0.
  - `busy`=0, `done`=0, `error`=0.
  - `err_addr`=0, `err_count`=0.
- All outputs are decoded from registered state and counters; no output depends combinationally on inputs.
- Free-run schedule, with `en` high in IDLE at cycle 0:
  - WRITE addresses 0..N-1 occupy cycles 1..N.
  - Each address then takes one READ and one CHECK cycle.
  - DONE is entered at cycle 3N+1 (N = 2^ADDR_WIDTH).
- Compare latency: address presented in READ during cycle t; RAM samples it at edge t+1; `data_in` is compared at the end of CHECK (cycle t+1).
- Step mode: one write per `en`; one read/compare per `en`. CHECK adds one cycle after each read `en`.

## Test plan
All scenarios use DATA_WIDTH=16, ADDR_WIDTH=4 (N=16) and a 1-cycle-latency RAM model.
1. Hold `reset`=0 with `next`=1, then release with `next` still 1 -> all outputs 0, state stays IDLE. Only a later 0->1 of `next` starts a run.
2. `run`=1, mode 0, clean RAM -> writes 0..15 with data=addr in cycles 1..16, `done`=1 at cycle 49, `error`=0, `err_count`=0.
3. `run`=1, mode 1, RAM model corrupts bit 0 of address 5 -> writes alternate AAAA/5555, `error`=1, `err_addr`=5, `err_count`=1.
4. Step mode, mode 2: pulse `next` four times, then hold it high for 10 cycles -> addresses 0..3 written with FFFF, FFFE, FFFD, FFFC; the hold produces exactly one more write (address 4, FFFB).
5. `run`=1, mode 3, RAM read data stuck at 0 -> `err_count`=16, `err_addr`=0, `done`=1 at cycle 49.
6. Assert `reset`=0 during the READ of address 7 after an earlier mismatch -> next cycle IDLE, all outputs 0, `err_count`=0. A new run completes cleanly.

Source files
------------

// File: rtl/mem_test_seq.sv
// Memory test sequencer: a write pass and then a verifying read pass over every
// address of a single-port synchronous RAM, with mismatch counting and first-fail capture.
module mem_test_seq #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  next,
  input  logic                  run,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [15:0]           err_count
);

  localparam int unsigned ERR_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [1:0]            mode_q;
  logic                  next_prev;
  logic                  edge_ok;
  logic                  en;

  logic                  cnt_max;
  logic [ADDR_WIDTH-1:0] cnt_inc;
  logic                  mismatch;

  // Test pattern for address a under pattern select m.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0] m,
                                                    input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] p;
    p = '0;
    case (m)
      2'd0:    p = DATA_WIDTH'(a);
      2'd1:    for (int unsigned i = 0; i < DATA_WIDTH; i++) p[i] = i[0] ^ a[0];
      2'd2:    p = ~DATA_WIDTH'(a);
      default: p = '1;
    endcase
    return p;
  endfunction

  assign cnt_max  = &cnt;
  assign cnt_inc  = cnt + ADDR_WIDTH'(1);
  assign mismatch = (data_in != pattern(mode_q, cnt));

  // Step enable; edge_ok blocks a level held high across reset release from
  // being taken as a press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      next_prev <= 1'b0;
      edge_ok   <= 1'b0;
      en        <= 1'b0;
    end else begin
      next_prev <= next;
      edge_ok   <= edge_ok | ~next;
      en        <= (next & ~next_prev & edge_ok) | run;
    end
  end

  // Sequencer with outputs registered alongside the state transition.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mode_q    <= 2'd0;
      wr_en     <= 1'b0;
      addr      <= '0;
      data_out  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            mode_q    <= mode;
            error     <= 1'b0;
            err_count <= '0;
            err_addr  <= '0;
            cnt       <= '0;
            state     <= WRITE;
            wr_en     <= 1'b1;
            addr      <= '0;
            data_out  <= pattern(mode, '0);
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        WRITE: begin
          if (en) begin
            if (cnt_max) begin
              cnt      <= '0;
              state    <= READ;
              wr_en    <= 1'b0;
              addr     <= '0;
              data_out <= '0;
            end else begin
              cnt      <= cnt_inc;
              addr     <= cnt_inc;
              data_out <= pattern(mode_q, cnt_inc);
            end
          end
        end
        READ: begin
          if (en) state <= CHECK;
        end
        CHECK: begin
          if (mismatch) begin
            if (err_count != {ERR_W{1'b1}}) err_count <= err_count + ERR_W'(1);
            if (!error) begin
              error    <= 1'b1;
              err_addr <= cnt;
            end
          end
          if (cnt_max) begin
            state <= DONE;
            addr  <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt   <= cnt_inc;
            addr  <= cnt_inc;
            state <= READ;
          end
        end
        DONE: begin
          if (en) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          wr_en    <= 1'b0;
          addr     <= '0;
          data_out <= '0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_test_seq.sv
// Directed bench for mem_test_seq with a 1-cycle-latency RAM model and a write scoreboard.
module tb_mem_test_seq;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          next;
  logic          run;
  logic [1:0]    mode;
  logic [DW-1:0] data_in;
  logic          wr_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW-1:0] err_addr;
  logic [15:0]   err_count;

  int tests = 0;
  int fails = 0;

  logic [AW+DW-1:0] exp_q[$];

  // RAM model with fault injection on the read path.
  logic [DW-1:0] mem [16];
  logic [DW-1:0] rd_q;
  logic [AW-1:0] rd_addr_q;
  logic          stuck0 = 1'b0;
  logic          corrupt = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;

  mem_test_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .next(next), .run(run), .mode(mode),
    .data_in(data_in), .wr_en(wr_en), .addr(addr), .data_out(data_out),
    .busy(busy), .done(done), .error(error), .err_addr(err_addr),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en) mem[addr] <= data_out;
    rd_q      <= mem[addr];
    rd_addr_q <= addr;
  end

  assign data_in = stuck0 ? '0 :
                   (corrupt && rd_addr_q == corrupt_addr) ? (rd_q ^ 16'h0001) : rd_q;

  function automatic logic [DW-1:0] pat(input logic [1:0] m, input logic [AW-1:0] a);
    case (m)
      2'd0:    return {12'h000, a};
      2'd1:    return a[0] ? 16'h5555 : 16'hAAAA;
      2'd2:    return ~{12'h000, a};
      default: return 16'hFFFF;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: each new write (address change or first cycle of wr_en) pops one entry.
  logic          prev_wr = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  always @(negedge clk) begin
    if (wr_en && (!prev_wr || addr != prev_addr)) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL wr_unexpected: observed %0h expected none", {addr, data_out});
      end else begin
        check("wr_addr_data", {addr, data_out}, exp_q.pop_front());
      end
    end
    prev_wr   = wr_en;
    prev_addr = addr;
  end

  task automatic push_pass(input logic [1:0] m);
    for (int a = 0; a < 16; a++) exp_q.push_back({AW'(a), pat(m, AW'(a))});
  endtask

  // Free-run pass; cycle 0 is the IDLE cycle with en high.
  task automatic run_pass(input logic [1:0] m, input string tag);
    int k;
    push_pass(m);
    mode = m;
    run  = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!wr_en && k < 20);
    check({tag, "_first_wr"}, 64'(k), 64'd2);
    k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_cycle"}, 64'(k + 1), 64'd49);
    run = 1'b0;
    check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    reset = 1'b0;
    next  = 1'b1;
    run   = 1'b0;
    mode  = 2'd2;

    // Reset with next held high, then release with next still high.
    tick(3);
    check("reset_outputs", {wr_en, addr, data_out, busy, done, error, err_addr, err_count}, 64'd0);
    reset = 1'b1;
    tick(5);
    check("held_next_idle", {wr_en, addr, data_out, busy, done}, 64'd0);

    // Step mode, pattern 2: real press starts the run and writes address 0.
    next = 1'b0;
    tick(1);
    for (int a = 0; a < 5; a++) exp_q.push_back({AW'(a), pat(2'd2, AW'(a))});
    next = 1'b1;
    tick(2);
    check("step_start", {busy, wr_en, addr, data_out}, {1'b1, 1'b1, 4'd0, 16'hFFFF});
    mode = 2'd0;
    for (int p = 0; p < 3; p++) begin
      next = 1'b0;
      tick(2);
      next = 1'b1;
      tick(2);
    end
    check("step_addr3", {addr, data_out}, {4'd3, 16'hFFFC});
    next = 1'b0;
    tick(2);
    next = 1'b1;
    tick(10);
    check("step_hold_one", {wr_en, addr, data_out}, {1'b1, 4'd4, 16'hFFFB});
    check("step_drain", 64'(exp_q.size()), 64'd0);
    next = 1'b0;
    reset = 1'b0;
    tick(1);
    check("abort_reset", {wr_en, addr, data_out, busy, done, error, err_addr, err_count}, 64'd0);
    reset = 1'b1;
    tick(2);

    // Free-run, mode 0, clean RAM.
    run_pass(2'd0, "m0");
    check("m0_result", {error, err_addr, err_count}, 64'd0);
    tick(3);
    check("m0_idle_kept", {busy, done, wr_en, error, err_count}, 64'd0);

    // Free-run, mode 1, bit 0 of address 5 corrupted on read.
    corrupt = 1'b1;
    corrupt_addr = 4'd5;
    run_pass(2'd1, "m1");
    check("m1_result", {error, err_addr, err_count}, {1'b1, 4'd5, 16'd1});
    tick(3);
    check("m1_kept", {done, error, err_addr, err_count}, {1'b0, 1'b1, 4'd5, 16'd1});
    corrupt = 1'b0;

    // Free-run, mode 3, read data stuck at zero.
    stuck0 = 1'b1;
    run_pass(2'd3, "m3");
    check("m3_result", {error, err_addr, err_count}, {1'b1, 4'd0, 16'd16});
    stuck0 = 1'b0;
    tick(3);

    // Reset during the READ of address 7 after a mismatch at address 2.
    corrupt = 1'b1;
    corrupt_addr = 4'd2;
    push_pass(2'd0);
    mode = 2'd0;
    run  = 1'b1;
    k = 0;
    while (!(busy && !wr_en && addr == 4'd7) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("mid_found_read7", {busy, wr_en, addr}, {1'b1, 1'b0, 4'd7});
    check("mid_err_before", {error, err_addr, err_count}, {1'b1, 4'd2, 16'd1});
    reset = 1'b0;
    run   = 1'b0;
    tick(1);
    check("mid_reset", {wr_en, addr, data_out, busy, done, error, err_addr, err_count}, 64'd0);
    reset = 1'b1;
    corrupt = 1'b0;
    tick(2);
    check("mid_idle", {busy, wr_en}, 64'd0);
    run_pass(2'd0, "rerun");
    check("rerun_result", {error, err_addr, err_count}, 64'd0);
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
